// File: rtl/execute_stage_mc_pkg.sv
// Shared encodings for the execute stage: funct codes, ALU/forwarding selects,
// control-bit positions and mul/div FSM states.
package exec_pkg;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_SLT   = 2'b11;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_MEM_READ   = 3;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_REG_WRITE  = 0;

  typedef logic [1:0] mdState_t;
  localparam mdState_t ST_IDLE = 2'd0;
  localparam mdState_t ST_MUL  = 2'd1;
  localparam mdState_t ST_DIV  = 2'd2;

  function automatic logic isMulDiv(input logic [5:0] f);
    return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV) || (f == FN_DIVU);
  endfunction

  function automatic logic usesHiLo(input logic [5:0] f);
    return isMulDiv(f) || (f == FN_MFHI) || (f == FN_MFLO);
  endfunction

endpackage

// File: rtl/execute_stage_mc_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one port.
interface execute_stage_mc_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 10,
  parameter int REG_W  = 5
);
  logic              in_valid;
  logic              in_hazard;
  logic [4:0]        in_ctrl;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_data1;
  logic [DATA_W-1:0] in_data2;
  logic [DATA_W-1:0] sign_extend;
  logic [REG_W-1:0]  rt;
  logic [REG_W-1:0]  rd;
  logic [1:0]        alu_op;
  logic              alu_src;
  logic              reg_dst;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] mem_data;
  logic              out_valid;
  logic [4:0]        out_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              zero;
  logic [DATA_W-1:0] out_data2;
  logic [REG_W-1:0]  wr;
  logic [PC_W-1:0]   out_pc;
  logic [PC_W-1:0]   out_current_pc;
  logic              stall;

  modport master (
    output in_valid, in_hazard, in_ctrl, in_pc, in_data1, in_data2, sign_extend,
           rt, rd, alu_op, alu_src, reg_dst, fwd_a, fwd_b, wb_data, mem_data,
    input  out_valid, out_ctrl, alu_result, zero, out_data2, wr, out_pc,
           out_current_pc, stall
  );

  modport slave (
    input  in_valid, in_hazard, in_ctrl, in_pc, in_data1, in_data2, sign_extend,
           rt, rd, alu_op, alu_src, reg_dst, fwd_a, fwd_b, wb_data, mem_data,
    output out_valid, out_ctrl, alu_result, zero, out_data2, wr, out_pc,
           out_current_pc, stall
  );
endinterface

// File: rtl/execute_stage_mc_mul_div_unit.sv
// Iterative one-bit-per-cycle multiply (shift-add) and divide (restoring)
// with HI/LO result registers; signed ops run on magnitudes.
module mul_div_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     issue,
  input  logic [1:0]               op,
  input  logic signed [DATA_W-1:0] opA,
  input  logic signed [DATA_W-1:0] opB,
  output logic                     busy,
  output logic signed [DATA_W-1:0] hi,
  output logic signed [DATA_W-1:0] lo
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  mdState_t            state;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   accHi, accLo, magB, rawA;
  logic                negQ, negR, divZero;
  logic                sgnOp;
  logic [DATA_W:0]     mulSum, remShift;
  logic [2*DATA_W-1:0] mulNext, prodFinal;
  logic [DATA_W-1:0]   remNext, quoNext, remFinal, quoFinal;
  logic                qBit;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic sgn);
    return (sgn && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

  // op[0] set selects the unsigned variant (multu/divu)
  assign sgnOp = ~op[0];
  assign busy  = (state != ST_IDLE);

  always_comb begin
    mulSum    = {1'b0, accHi} + (accLo[0] ? {1'b0, magB} : '0);
    mulNext   = {mulSum, accLo[DATA_W-1:1]};
    prodFinal = negQ ? (~mulNext + 1'b1) : mulNext;
    remShift  = {accHi, accLo[DATA_W-1]};
    qBit      = (remShift >= {1'b0, magB});
    remNext   = qBit ? DATA_W'(remShift - {1'b0, magB}) : remShift[DATA_W-1:0];
    quoNext   = {accLo[DATA_W-2:0], qBit};
    remFinal  = negR ? (~remNext + 1'b1) : remNext;
    quoFinal  = negQ ? (~quoNext + 1'b1) : quoNext;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      accHi   <= '0;
      accLo   <= '0;
      magB    <= '0;
      rawA    <= '0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      divZero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            state   <= op[1] ? ST_DIV : ST_MUL;
            cnt     <= CNT_W'(DATA_W);
            accHi   <= '0;
            accLo   <= magnitude(opA, sgnOp);
            magB    <= magnitude(opB, sgnOp);
            rawA    <= opA;
            negQ    <= sgnOp & (opA[DATA_W-1] ^ opB[DATA_W-1]);
            negR    <= sgnOp & opA[DATA_W-1];
            divZero <= (opB == '0);
          end
        end
        ST_MUL: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            {hi, lo} <= prodFinal;
            state    <= ST_IDLE;
          end else begin
            {accHi, accLo} <= mulNext;
          end
        end
        ST_DIV: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            // divide by zero reports the raw dividend in HI and all ones in LO
            hi    <= divZero ? rawA : remFinal;
            lo    <= divZero ? '1 : quoFinal;
            state <= ST_IDLE;
          end else begin
            accHi <= remNext;
            accLo <= quoNext;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/execute_stage_mc.sv
// MIPS execute stage: forwarding, ALU, destination select, branch target and
// EX/MEM register, with a multi-cycle mul/div unit and HI/LO-hazard stall.
module execute_stage_mc
  import exec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 10,
  parameter int REG_W  = 5
) (
  input logic               clock,
  input logic               reset,
  execute_stage_mc_if.slave ex
);
  logic [5:0]               funct;
  logic [4:0]               shamt;
  logic signed [DATA_W-1:0] opA, opB, aluB, aluRes, hi, lo;
  logic                     busy, accept, issue;

  logic                     vld_p1, zero_p1;
  logic [4:0]               ctrl_p1;
  logic signed [DATA_W-1:0] res_p1, data2_p1;
  logic [REG_W-1:0]         wr_p1;
  logic [PC_W-1:0]          pc_p1, curPc_p1;

  function automatic logic [DATA_W-1:0] fwdSel(input logic [1:0] sel,
                                               input logic [DATA_W-1:0] regVal,
                                               input logic [DATA_W-1:0] wbVal,
                                               input logic [DATA_W-1:0] memVal);
    case (sel)
      FWD_WB:  return wbVal;
      FWD_MEM: return memVal;
      default: return regVal;
    endcase
  endfunction

  assign funct = ex.sign_extend[5:0];
  assign shamt = ex.sign_extend[10:6];
  assign opA   = fwdSel(ex.fwd_a, ex.in_data1, ex.wb_data, ex.mem_data);
  assign opB   = fwdSel(ex.fwd_b, ex.in_data2, ex.wb_data, ex.mem_data);
  assign aluB  = ex.alu_src ? ex.sign_extend : opB;

  always_comb begin
    aluRes = '0;
    case (ex.alu_op)
      ALU_ADD: aluRes = opA + aluB;
      ALU_SUB: aluRes = opA - aluB;
      ALU_SLT: aluRes = DATA_W'(opA < aluB);
      default: begin
        case (funct)
          FN_ADD, FN_ADDU: aluRes = opA + aluB;
          FN_SUB, FN_SUBU: aluRes = opA - aluB;
          FN_AND:  aluRes = opA & aluB;
          FN_OR:   aluRes = opA | aluB;
          FN_XOR:  aluRes = opA ^ aluB;
          FN_NOR:  aluRes = ~(opA | aluB);
          FN_SLT:  aluRes = DATA_W'(opA < aluB);
          FN_SLTU: aluRes = DATA_W'($unsigned(opA) < $unsigned(aluB));
          FN_SLL:  aluRes = aluB << shamt;
          FN_SRL:  aluRes = $unsigned(aluB) >> shamt;
          FN_SRA:  aluRes = aluB >>> shamt;
          FN_MFHI: aluRes = hi;
          FN_MFLO: aluRes = lo;
          default: aluRes = '0;
        endcase
      end
    endcase
  end

  // any HI/LO user waits for the unit; stall forces a bubble into EX/MEM
  assign ex.stall = busy & ex.in_valid & ex.in_hazard & usesHiLo(funct);
  assign accept   = ex.in_valid & ex.in_hazard & ~ex.stall;
  assign issue    = accept & (ex.alu_op == ALU_RTYPE) & isMulDiv(funct);

  mul_div_unit #(.DATA_W(DATA_W)) mdu (
    .clock (clock),
    .reset (reset),
    .issue (issue),
    .op    (funct[1:0]),
    .opA   (opA),
    .opB   (opB),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  // EX/MEM boundary
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      ctrl_p1  <= '0;
      res_p1   <= '0;
      zero_p1  <= 1'b0;
      data2_p1 <= '0;
      wr_p1    <= '0;
      pc_p1    <= '0;
      curPc_p1 <= '0;
    end else begin
      vld_p1  <= accept;
      ctrl_p1 <= accept ? ex.in_ctrl : 5'b0;
      if (accept) begin
        res_p1   <= aluRes;
        zero_p1  <= (aluRes == '0);
        data2_p1 <= opB;
        wr_p1    <= ex.reg_dst ? ex.rd : ex.rt;
        pc_p1    <= ex.in_pc + ex.sign_extend[PC_W-1:0];
        curPc_p1 <= ex.in_pc;
      end
    end
  end

  assign ex.out_valid      = vld_p1;
  assign ex.out_ctrl       = ctrl_p1;
  assign ex.alu_result     = res_p1;
  assign ex.zero           = zero_p1;
  assign ex.out_data2      = data2_p1;
  assign ex.wr             = wr_p1;
  assign ex.out_pc         = pc_p1;
  assign ex.out_current_pc = curPc_p1;

endmodule

// File: doc/execute_stage_mc.md
# execute_stage_mc

Parametrised MIPS execute stage with an integrated multi-cycle multiply/divide unit. It sits between the ID/EX and EX/MEM boundaries and performs several functions:
- operand forwarding and ALU operation;
- destination-register select;
- branch-target computation;
- registration of all results into the EX/MEM pipeline register.

It adds HI/LO registers, iterative `mult`/`div` and a stall output that freezes upstream stages while a HI/LO-dependent instruction waits on the busy unit.

## Interface
Parameters:
- `DATA_W`, 32: datapath width; must be even and at least 8.
- `PC_W`, 10: PC width, in words.
- `REG_W`, 5: register-address width.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `in_valid`  in  1  an instruction is present at ID/EX.
- `in_hazard`  in  1  hazard unit: 1 = proceed, 0 = insert bubble.
- `in_ctrl`  in  5  {branch, mem_read, mem_write, mem_to_reg, reg_write}.
- `in_pc`  in  `PC_W`  PC of the instruction.
- `in_data1`, `in_data2`  in  `DATA_W`  register-file rs and rt values.
- `sign_extend`  in  `DATA_W`  sign-extended instr[15:0]; [5:0] = funct, [10:6] = shamt.
- `rt`, `rd`  in  `REG_W`  register addresses.
- `alu_op`  in  2  00 add, 01 sub, 10 R-type (decode funct), 11 slt.
- `alu_src`  in  1  0 = forwarded B operand, 1 = `sign_extend`.
- `reg_dst`  in  1  0 = rt, 1 = rd.
- `fwd_a`, `fwd_b`  in  2  forwarding select: 00 register file, 01 `wb_data`, 10 `mem_data`, 11 treated as 00.
- `wb_data`, `mem_data`  in  `DATA_W`  forwarded values from WB and from EX/MEM.
- `out_valid`  out  1  the EX/MEM slot holds a real instruction.
- `out_ctrl`  out  5  registered `in_ctrl`; zero on a bubble.
- `alu_result`  out  `DATA_W`  registered ALU result or HI/LO.
- `zero`  out  1  registered (`alu_result` == 0).
- `out_data2`  out  `DATA_W`  registered forwarded B value (not the immediate); store data.
- `wr`  out  `REG_W`  registered destination register.
- `out_pc`  out  `PC_W`  registered `in_pc` + `sign_extend`[`PC_W`-1:0], modulo 2^`PC_W`.
- `out_current_pc`  out  `PC_W`  registered `in_pc`.
- `stall`  out  1  combinational; 1 = hold ID/EX and earlier stages.

## Operation
ALU functions under `alu_op`=10, selected by funct:
- arithmetic: 0x20/0x21 add, 0x22/0x23 sub, all wrap with no overflow trap;
- logic: 0x24 and, 0x25 or, 0x26 xor, 0x27 nor;
- compare: 0x2A slt (signed), 0x2B sltu;
- shifts by shamt on B: 0x00 sll, 0x02 srl, 0x03 sra;
- HI/LO reads: 0x10 mfhi, 0x12 mflo;
- mul/div: 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu;
- any other funct: result 0.

Bubbles and acceptance:
- Accept = `in_valid` & `in_hazard` & ~`stall`.
- On a non-accept edge, `out_ctrl` = 0 and `out_valid` = 0; the other EX/MEM fields hold their values; no mul/div is issued.

Mul/div unit, FSM IDLE → MUL or DIV → IDLE:
- Issue: accepted mult/div in IDLE. Capture the forwarded operands and load a counter with `DATA_W`.
- The issuing instruction passes to EX/MEM normally, with `alu_result` = 0.
- MUL: shift-add, one bit per cycle. DIV: restoring division, one bit per cycle. Signed ops work on magnitudes, with the sign fixed on the final cycle.
- Final cycle writes HI = upper half or remainder, LO = lower half or quotient, then returns to IDLE.
- Divide by zero: HI = dividend, LO = all ones.
- div MIN / −1: LO = MIN, HI = 0.

Stall:
- `stall` = busy & `in_valid` & `in_hazard` & (incoming funct ∈ {mfhi, mflo, mult, multu, div, divu}).
- Independent instructions flow while the unit is busy.

## Timing
- Reset asserted: every output 0 asynchronously, FSM IDLE, HI = LO = 0, `stall` = 0.
- Reset mid-operation aborts the operation; no HI/LO update.
- ALU path latency: 1 cycle. Inputs in cycle N appear on the outputs after edge N.
- Mul/div:
  - Issue on edge E; busy during the `DATA_W` cycles following E.
  - HI/LO are written on edge E+`DATA_W`, and busy clears there.
  - A dependent instruction presented right after E is stalled for `DATA_W` cycles, accepted on edge E+`DATA_W`+1, and reads the new HI/LO.
- Bubble and stall are simultaneous: stall wins, and EX/MEM receives a bubble.

## Structure
- Package `exec_pkg`: funct codes, `alu_op` encodings, forwarding-select encodings, `in_ctrl` bit indices, FSM state enum.
- One sub-module, `mul_div_unit`: the FSM, counter and HI/LO registers. It has an issue/busy interface and exposes HI and LO.

## Test plan
- AND: data1 = 1, data2 = 1, funct 0x24, `reg_dst` = 1, rd = 12 → after one edge `alu_result` = 1, `wr` = 12, `zero` = 0.
- Forwarding, each case with `alu_op` = 10, funct 0x24 (AND):
  - `fwd_a` = 10, `mem_data` = 4, data2 = 1 → `alu_result` = 0, `zero` = 1;
  - `fwd_b` = 01, `wb_data` = 3, data1 = 1 → `alu_result` = 1;
  - `fwd_a` = 11, data1 = 1, data2 = 1 → treated as 00, `alu_result` = 1.
- mult −3 × 5, then mflo presented immediately → `stall` high for 32 cycles; mflo result = 0xFFFFFFF1; a following mfhi returns 0xFFFFFFFF.
- Divide corner cases:
  - divu 7 / 0 → HI = 7, LO = 0xFFFFFFFF;
  - div 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- `in_hazard` = 0 with `in_ctrl` = 5'b00001 → `out_ctrl` = 0, `out_valid` = 0, `wr` unchanged; a mult presented under the bubble is not issued.
- Reset low 10 cycles into a div → outputs 0 immediately, `stall` = 0, HI/LO = 0. Rerun with `DATA_W` = 16: multu 0x00FF × 0x0101 → LO = 0xFFFF, HI = 0x0000 after 16 cycles.
